// File: rtl/conv_cache_shift_ctrl_pkg.sv
// Shared types and constants for the conv line-cache shift controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the FSM state encoding, the 10-bit address/count width shared with the
// ram-based shift register, and the window-qualification helper.
// Optional feature macro used by the bundle: CONV_CACHE_FLUSH_EN.

`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 8
`endif

package conv_cache_shift_ctrl_pkg;

  // Address/count width, identical to the shift register's shift_size port.
  localparam int ADDR_W  = 10;
  // Flush counter must reach row_size + 1 (max 1024), hence one extra bit.
  localparam int FLUSH_W = ADDR_W + 1;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A beat completes a KxK window once both indices reach K-1.
  function automatic logic win_hit(addr_t row, addr_t col, int unsigned kernel);
    return (row >= ADDR_W'(kernel - 1)) && (col >= ADDR_W'(kernel - 1));
  endfunction

endpackage

// File: rtl/conv_cache_shift_ctrl_if.sv
// Bundle of the feature stream, shift-register drive and window/status signals.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carried here; the controller owns in_ready.
//
// master: feature-fetch / testbench side (drives start, config, stream, out_ready)
// slave : controller side (drives in_ready, sr_*, win_*, busy, done, cfg_err)

`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 8
`endif

interface conv_cache_shift_ctrl_if
  import conv_cache_shift_ctrl_pkg::*;
#(
  parameter int FEATURE_WIDTH = `FEATURE_WIDTH
);
  logic                         start;
  addr_t                        cfg_row_size;
  addr_t                        cfg_row_num;
  logic                         in_valid;
  logic [2*FEATURE_WIDTH-1:0]   in_data;
  logic                         in_ready;
  logic                         out_ready;
  logic                         sr_wr_en;
  logic [2*FEATURE_WIDTH-1:0]   sr_wr_data;
  addr_t                        sr_shift_size;
  logic                         win_valid;
  addr_t                        win_row;
  addr_t                        win_col;
  logic                         busy;
  logic                         done;
  logic                         cfg_err;

  modport master (
    output start, cfg_row_size, cfg_row_num, in_valid, in_data, out_ready,
    input  in_ready, sr_wr_en, sr_wr_data, sr_shift_size,
           win_valid, win_row, win_col, busy, done, cfg_err
  );

  modport slave (
    input  start, cfg_row_size, cfg_row_num, in_valid, in_data, out_ready,
    output in_ready, sr_wr_en, sr_wr_data, sr_shift_size,
           win_valid, win_row, win_col, busy, done, cfg_err
  );

endinterface

// File: rtl/conv_cache_shift_ctrl_pos_counter.sv
// Column/row position counter with row wrap and last-beat detect.
// Latency: indices update on the clock edge that accepts a beat; flags are combinational.
// Backpressure: advances only on adv_i; holds otherwise.
//
// Ports: clk/rst_n; clear_i zeroes both counters; adv_i steps one beat;
// row_size_i/row_num_i are the latched limits; col_o/row_o current indices;
// last_o flags the final beat of the frame.

module conv_pos_counter
  import conv_cache_shift_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clear_i,
  input  logic  adv_i,
  input  addr_t row_size_i,
  input  addr_t row_num_i,
  output addr_t col_o,
  output addr_t row_o,
  output logic  last_o
);

  addr_t col_q, col_d;
  addr_t row_q, row_d;
  logic  row_end;

  // With W=1 col stays 0 and every beat is a row end.
  assign row_end = (col_q == row_size_i - 1'b1);
  assign last_o  = row_end && (row_q == row_num_i - 1'b1);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (adv_i) begin
      // Last beat wins over row end so the next frame starts at (0,0).
      if (last_o) begin
        col_d = '0;
        row_d = '0;
      end else if (row_end) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;

endmodule

// File: rtl/conv_cache_shift_ctrl.sv
// Sequencer driving the conv line-cache shift register from a packed feature stream.
// Latency: write is combinational with the accept; win_* and done are 1 cycle later.
// Backpressure: in_ready follows out_ready in RUN; out_ready low stalls RUN and FLUSH.
//
// Ports: system_clk, rst_n (async, active-low); bus (slave modport) carries
// start/cfg_row_size/cfg_row_num, the in_* stream, out_ready, the sr_* shift
// register drive, win_valid/win_row/win_col and busy/done/cfg_err status.
// Build option: define CONV_CACHE_FLUSH_EN to append row_size+2 zero words after
// the last input beat; otherwise the last beat goes straight to DONE.

`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 8
`endif

module conv_cache_shift_ctrl
  import conv_cache_shift_ctrl_pkg::*;
#(
  parameter int FEATURE_WIDTH = `FEATURE_WIDTH,
  parameter int KERNEL        = 3
)(
  input  logic                     system_clk,
  input  logic                     rst_n,
  conv_cache_shift_ctrl_if.slave   bus
);

  state_t state_q;
  addr_t  row_size_q;
  addr_t  row_num_q;
  logic   win_valid_q;
  addr_t  win_row_q;
  addr_t  win_col_q;
  logic   busy_q;
  logic   done_q;
  logic   cfg_err_q;

  logic   cfg_ok;
  logic   start_ok;
  logic   accept;
  logic   flush_wr;
  addr_t  col;
  addr_t  row;
  logic   last_beat;

  assign cfg_ok   = (bus.cfg_row_size != '0) && (bus.cfg_row_num != '0);
  assign start_ok = (state_q == IDLE) && bus.start && cfg_ok;
  assign accept   = (state_q == RUN) && bus.out_ready && bus.in_valid;

`ifdef CONV_CACHE_FLUSH_EN
  logic [FLUSH_W-1:0] flush_cnt_q;
  logic               flush_last;
  // Writes indexed 0 .. row_size+1, so the last one is at row_size+1.
  assign flush_last = (flush_cnt_q == ({1'b0, row_size_q} + FLUSH_W'(1)));
  assign flush_wr   = (state_q == FLUSH) && bus.out_ready;
`else
  assign flush_wr   = 1'b0;
`endif

  conv_pos_counter u_pos (
    .clk        (system_clk),
    .rst_n      (rst_n),
    .clear_i    (start_ok),
    .adv_i      (accept),
    .row_size_i (row_size_q),
    .row_num_i  (row_num_q),
    .col_o      (col),
    .row_o      (row),
    .last_o     (last_beat)
  );

  // The write lands in the same cycle as the accept; flush words are zero.
  assign bus.in_ready   = (state_q == RUN) && bus.out_ready;
  assign bus.sr_wr_en   = accept || flush_wr;
  assign bus.sr_wr_data = accept ? bus.in_data : '0;

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_size_q  <= '0;
      row_num_q   <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
`ifdef CONV_CACHE_FLUSH_EN
      flush_cnt_q <= '0;
`endif
    end else begin
      win_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (cfg_ok) begin
              row_size_q <= bus.cfg_row_size;
              row_num_q  <= bus.cfg_row_num;
              busy_q     <= 1'b1;
              state_q    <= RUN;
            end else begin
              cfg_err_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            // Registered to line up with the shift register's read data.
            win_valid_q <= win_hit(row, col, KERNEL);
            win_row_q   <= row;
            win_col_q   <= col;
            if (last_beat) begin
`ifdef CONV_CACHE_FLUSH_EN
              flush_cnt_q <= '0;
              state_q     <= FLUSH;
`else
              done_q      <= 1'b1;
              state_q     <= DONE;
`endif
            end
          end
        end
`ifdef CONV_CACHE_FLUSH_EN
        FLUSH: begin
          if (bus.out_ready) begin
            if (flush_last) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              flush_cnt_q <= flush_cnt_q + 1'b1;
            end
          end
        end
`endif
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.sr_shift_size = row_size_q;
  assign bus.win_valid     = win_valid_q;
  assign bus.win_row       = win_row_q;
  assign bus.win_col       = win_col_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.cfg_err       = cfg_err_q;

endmodule

// File: doc/conv_cache_shift_ctrl.md
# conv_cache_shift_ctrl

Sequencing controller for the convolution line-cache shift register. Accepts a packed feature stream (two features per word) and drives the shift register's write enable, write data and shift size. Counts column and row position to flag when a full KERNEL×KERNEL window is present, then optionally flushes the cache tail with zero words. It sits between the feature-fetch stage and the ram-based shift register inside the conv component.

## Interface
- `FEATURE_WIDTH`, default `` `FEATURE_WIDTH ``: width of one feature; the data word is 2×FEATURE_WIDTH.
- `KERNEL`, default 3: kernel edge; window becomes valid at row ≥ KERNEL-1 and col ≥ KERNEL-1.
- `system_clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: one-cycle pulse that latches the config and begins a frame.
- `cfg_row_size`, in, 10: words per row (W), 1..1023.
- `cfg_row_num`, in, 10: rows per frame (H), 1..1023.
- `in_valid`, in, 1: input word valid.
- `in_data`, in, 2×FEATURE_WIDTH: input word.
- `in_ready`, out, 1: input word accepted when `in_valid & in_ready`.
- `out_ready`, in, 1: downstream window consumer can take a beat.
- `sr_wr_en`, out, 1: to shift register `wr_en`.
- `sr_wr_data`, out, 2×FEATURE_WIDTH: to shift register `wr_data`.
- `sr_shift_size`, out, 10: to shift register `shift_size`.
- `win_valid`, out, 1: the shift register output this cycle completes a window.
- `win_row`, out, 10: row index of the beat that produced the window.
- `win_col`, out, 10: column index of that beat.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at frame end.
- `cfg_err`, out, 1: one-cycle pulse when `start` is rejected.

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: on `start` with `cfg_row_size`≠0 and `cfg_row_num`≠0, latch the config into `row_size_q` and `row_num_q`, clear `col` and `row`, then go to RUN. Any zero field pulses `cfg_err` and stays in IDLE.
- `start` in any state other than IDLE is ignored; no `cfg_err`.
- `sr_shift_size` = `row_size_q`. It holds constant from the latch until the next accepted `start`.
- RUN:
  - `in_ready` = `out_ready`.
  - On accept: `sr_wr_en`=1, `sr_wr_data`=`in_data`, then `col`++.
  - When `col`=`row_size_q`-1: `col`←0, `row`++.
  - Accepting the last beat (`row`=`row_num_q`-1, `col`=`row_size_q`-1) moves to FLUSH (or DONE, see Configuration).
- Window flag: an accepted beat with `row`≥KERNEL-1 and `col`≥KERNEL-1 sets `win_valid` next cycle, with `win_row`/`win_col` holding that beat's indices.
- FLUSH: writes `row_size_q`+2 zero words, one per cycle while `out_ready`=1, using an 11-bit counter. `in_ready`=0 and `win_valid`=0 throughout. After the last flush write, go to DONE.
- DONE: pulse `done` for one cycle, then return to IDLE.
- Counter wrap: `col` and `row` never exceed their latched limit minus 1. W=1 means every beat is a row end. Row-end and last-beat on the same beat: last-beat takes priority (go to FLUSH, counters cleared).
- Reset mid-frame: everything returns to IDLE at once, with reset values. Shift register contents are not cleared.

## Timing
- Reset values:
  - `in_ready`, `sr_wr_en`, `win_valid`, `busy`, `done`, `cfg_err` = 0.
  - `sr_wr_data`, `sr_shift_size`, `win_row`, `win_col` = 0.
- `in_ready`, `sr_wr_en` and `sr_wr_data` are combinational from state, `out_ready` and `in_valid`/`in_data`, so the write lands in the same cycle as the accept.
- `win_valid`/`win_row`/`win_col` are registered, 1 cycle after the qualifying write, to align with the shift register's registered read data.
- `busy` rises the cycle after an accepted `start`. `cfg_err` appears the cycle after a rejected `start`.
- `done` rises 1 cycle after the final write (last flush word, or last input beat without flush).
- `out_ready`=0 stalls both RUN and FLUSH with no write. A stall never drops or duplicates a beat.

## Configuration
- `CONV_CACHE_FLUSH_EN`:
  - Defined: the FLUSH state is built, and the last input beat goes to FLUSH.
  - Undefined: FLUSH and its counter are not built, the last beat goes straight to DONE, and no zero words are written.

## Structure
- Shared package/header holds:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, FLUSH=2'd2, DONE=2'd3.
  - The 10-bit address/count width constant reused by the shift register.
- One sub-module: `conv_pos_counter`, the column/row counter pair with wrap and last-beat detect. The FSM stays in the top.

## Test plan
- Reset, then W=4, H=3, 12 words streamed, `out_ready`=1 → `win_valid` on 2 beats: (2,2) and (2,3). Then, with flush enabled, 6 zero writes and a `done` pulse.
- `start` with W=0 → `cfg_err` pulse, `busy` stays 0, no writes.
- Random `out_ready` and `in_valid` gaps with W=5, H=4 → exactly 20 accepts in order, `win_row`/`win_col` sequence matches a model.
- W=1, H=3 → every beat increments `row`, no `win_valid` (col never ≥2), `done` after the tail.
- Assert `rst_n` low mid-RUN at row 1, col 2 → all outputs 0 the same cycle. A fresh `start` restarts from (0,0).
- Flush disabled, W=3, H=3 → `done` exactly 1 cycle after the 9th accept, `sr_wr_en` never asserted after it.
